// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the PLL reset/lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PRST   = 3'd0,
    WLOCK  = 3'd1,
    STABLE = 3'd2,
    RUN    = 3'd3,
    FAIL   = 3'd4
  } seq_state_e;

  // Defaults for a 24 MHz reference
  localparam int unsigned RST_CYC_DEF          = 240;
  localparam int unsigned LOCK_TIMEOUT_CYC_DEF = 48000;
  localparam int unsigned STABLE_CYC_DEF       = 2400;
  localparam int unsigned MAX_RETRY_DEF        = 4;
  localparam int unsigned SYNC_STAGES_DEF      = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic N-flop synchroniser for asynchronous status inputs.
module sync_ff #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned W      = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] chain;

  always_ff @(posedge clk) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_rst_seq.sv
// PLL reset/lock sequencer: pulses PLL reset, qualifies lock, releases downstream reset,
// retries on timeout, latches failure and counts lock losses.
module pll_lock_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYC          = RST_CYC_DEF,
  parameter int unsigned LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
  parameter int unsigned STABLE_CYC       = STABLE_CYC_DEF,
  parameter int unsigned MAX_RETRY        = MAX_RETRY_DEF,
  parameter int unsigned SYNC_STAGES      = SYNC_STAGES_DEF
) (
  input  logic       clkin,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       restart_req,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       pll_ready,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  localparam int unsigned TMAX    = max3(RST_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC);
  localparam int unsigned TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  seq_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         retry_q, retry_d;
  logic [7:0]         relock_q, relock_d;
  logic               lock_s;
  logic               pll_reset_d, sys_rst_n_d, pll_ready_d, fail_d;

  sync_ff #(.STAGES(SYNC_STAGES), .W(1)) u_lock_sync (
    .clk     (clkin),
    .reset_n (reset_n),
    .d       (pll_lock),
    .q       (lock_s)
  );

  // State, counters and output registers
  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      state_q   <= PRST;
      timer_q   <= '0;
      retry_q   <= '0;
      relock_q  <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      pll_ready <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      relock_q  <= relock_d;
      pll_reset <= pll_reset_d;
      sys_rst_n <= sys_rst_n_d;
      pll_ready <= pll_ready_d;
      fail      <= fail_d;
    end
  end

  // Next state; outputs follow the next state so they are valid with it
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TIMER_W'(1);
    retry_d  = retry_q;
    relock_d = relock_q;

    if (restart_req) begin
      state_d = PRST;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        PRST: begin
          if (timer_q == TIMER_W'(RST_CYC - 1)) begin
            state_d = WLOCK;
            timer_d = '0;
          end
        end
        WLOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            timer_d = '0;
          end else if (timer_q == TIMER_W'(LOCK_TIMEOUT_CYC - 1)) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == 4'(MAX_RETRY)) ? FAIL : PRST;
            timer_d = '0;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WLOCK;
            timer_d = '0;
          end else if (timer_q == TIMER_W'(STABLE_CYC - 1)) begin
            state_d = RUN;
            timer_d = '0;
            retry_d = '0;
          end
        end
        RUN: begin
          timer_d = '0;
          if (!lock_s) begin
            state_d = PRST;
            if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
          end
        end
        FAIL: begin
          timer_d = '0;
        end
        default: begin
          state_d = PRST;
          timer_d = '0;
        end
      endcase
    end

    pll_reset_d = (state_d == PRST) || (state_d == FAIL);
    sys_rst_n_d = (state_d == RUN);
    pll_ready_d = (state_d == RUN);
    fail_d      = (state_d == FAIL);
  end

  assign relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Randomised and directed bench for pll_lock_rst_seq against a mode/elapsed-time model.
module tb_pll_lock_rst_seq;

  localparam int unsigned RST_CYC          = 4;
  localparam int unsigned LOCK_TIMEOUT_CYC = 20;
  localparam int unsigned STABLE_CYC       = 8;
  localparam int unsigned MAX_RETRY        = 2;
  localparam int unsigned SYNC_STAGES      = 2;

  logic       clkin = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       restart_req = 1'b0;
  logic       pll_reset, sys_rst_n, pll_ready, fail;
  logic [7:0] relock_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clkin = ~clkin;

  pll_lock_rst_seq #(
    .RST_CYC          (RST_CYC),
    .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
    .STABLE_CYC       (STABLE_CYC),
    .MAX_RETRY        (MAX_RETRY),
    .SYNC_STAGES      (SYNC_STAGES)
  ) dut (
    .clkin       (clkin),
    .reset_n     (reset_n),
    .pll_lock    (pll_lock),
    .restart_req (restart_req),
    .pll_reset   (pll_reset),
    .sys_rst_n   (sys_rst_n),
    .pll_ready   (pll_ready),
    .fail        (fail),
    .relock_cnt  (relock_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: operating mode, cycles spent in it, and a lock history
  typedef enum {M_PULSE, M_WAIT, M_QUAL, M_RUN, M_DEAD} mode_e;
  mode_e m_mode = M_PULSE;
  int    m_elapsed = 0;
  int    m_timeouts = 0;
  int    m_drops = 0;
  bit    m_hist[$];

  function automatic void enter(input mode_e m);
    m_mode    = m;
    m_elapsed = 0;
  endfunction

  function automatic void model_edge(input bit rn, input bit rq, input bit lk);
    bit seen;
    seen = m_hist[SYNC_STAGES-1];
    m_hist.push_front(lk);
    void'(m_hist.pop_back());
    if (!rn) begin
      enter(M_PULSE);
      m_timeouts = 0;
      m_drops    = 0;
      foreach (m_hist[i]) m_hist[i] = 1'b0;
      return;
    end
    if (rq) begin
      enter(M_PULSE);
      m_timeouts = 0;
      return;
    end
    m_elapsed++;
    case (m_mode)
      M_PULSE: if (m_elapsed == int'(RST_CYC)) enter(M_WAIT);
      M_WAIT: begin
        if (seen) enter(M_QUAL);
        else if (m_elapsed == int'(LOCK_TIMEOUT_CYC)) begin
          m_timeouts++;
          enter((m_timeouts == int'(MAX_RETRY)) ? M_DEAD : M_PULSE);
        end
      end
      M_QUAL: begin
        if (!seen) enter(M_WAIT);
        else if (m_elapsed == int'(STABLE_CYC)) begin
          m_timeouts = 0;
          enter(M_RUN);
        end
      end
      M_RUN: begin
        if (!seen) begin
          m_drops = (m_drops < 255) ? m_drops + 1 : 255;
          enter(M_PULSE);
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [11:0] model_out();
    logic pr, run, dead;
    pr   = (m_mode == M_PULSE) || (m_mode == M_DEAD);
    run  = (m_mode == M_RUN);
    dead = (m_mode == M_DEAD);
    return {pr, run, run, dead, 8'(m_drops)};
  endfunction

  // One clock: model advances on the edge, outputs compared on the falling edge
  task automatic cycle();
    @(posedge clkin);
    model_edge(reset_n, restart_req, pll_lock);
    @(negedge clkin);
    check_eq("outputs", {20'd0, pll_reset, sys_rst_n, pll_ready, fail, relock_cnt},
             {20'd0, model_out()});
  endtask

  task automatic pulse_restart();
    restart_req = 1'b1;
    cycle();
    restart_req = 1'b0;
  endtask

  task automatic wait_reset_low(input string tag);
    int n = 0;
    while (pll_reset && n < 200) begin cycle(); n++; end
    check_eq(tag, 32'(pll_reset), 32'd0);
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (!sys_rst_n && n < 200) begin cycle(); n++; end
    check_eq(tag, 32'(sys_rst_n), 32'd1);
  endtask

  initial begin
    int n, hi, lo, rises, seg;
    bit prev;
    m_hist = {};
    for (int i = 0; i < int'(SYNC_STAGES); i++) m_hist.push_back(1'b0);

    // Reset values
    repeat (3) cycle();
    check_eq("reset_outs", {28'd0, pll_reset, sys_rst_n, pll_ready, fail}, 32'b1000);
    check_eq("reset_relock", 32'(relock_cnt), 32'd0);

    // Scenario 1: 4-cycle PLL reset, release 11 cycles after lock rises
    reset_n = 1'b1;
    n = 1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (pll_reset) n++; else break;
    end
    check_eq("s1_prst_len", 32'(n), 32'd4);
    cycle(); cycle();
    pll_lock = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(); n++;
      if (sys_rst_n) break;
    end
    check_eq("s1_release_lat", 32'(n), 32'd11);
    check_eq("s1_ready", 32'(pll_ready), 32'd1);
    check_eq("s1_relock", 32'(relock_cnt), 32'd0);

    // Scenario 5a: restart coincides with lock_s falling in RUN
    pll_lock = 1'b0;
    cycle(); cycle();
    pulse_restart();
    check_eq("s5_restart_prst", 32'(pll_reset), 32'd1);
    check_eq("s5_relock_kept", 32'(relock_cnt), 32'd0);
    // Scenario 5b: lock_s rises on the timeout cycle in WLOCK
    wait_reset_low("s5_wlock");
    repeat (17) cycle();
    pll_lock = 1'b1;
    repeat (3) cycle();
    check_eq("s5_lock_beats_timeout", 32'(pll_reset), 32'd0);
    wait_run("s5_run");

    // Scenario 3: lock dip restarts the stable window
    pll_lock = 1'b0;
    pulse_restart();
    wait_reset_low("s3_wlock");
    pll_lock = 1'b1;
    repeat (5) cycle();
    pll_lock = 1'b0;
    repeat (2) cycle();
    check_eq("s3_no_release_in_dip", 32'(sys_rst_n), 32'd0);
    pll_lock = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(); n++;
      if (sys_rst_n) break;
    end
    check_eq("s3_release_lat", 32'(n), 32'd11);

    // Scenario 4: lock loss in RUN, then saturation of relock_cnt
    pll_lock = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(); n++;
      pll_lock = 1'b1;
      if (!sys_rst_n) break;
    end
    check_eq("s4_drop_lat", 32'(n), 32'(SYNC_STAGES + 1));
    check_eq("s4_pll_reset", 32'(pll_reset), 32'd1);
    wait_run("s4_rerun");
    check_eq("s4_relock1", 32'(relock_cnt), 32'd1);
    for (int k = 0; k < 256; k++) begin
      pll_lock = 1'b0;
      cycle();
      pll_lock = 1'b1;
      n = 0;
      while (sys_rst_n && n < 20) begin cycle(); n++; end
      wait_run("s4_loop_run");
    end
    check_eq("s4_relock_sat", 32'(relock_cnt), 32'd255);

    // Scenario 2: no lock -> two pulses 20 apart, then FAIL
    pll_lock = 1'b0;
    pulse_restart();
    hi = 1; lo = 0; rises = 1; prev = 1'b1;
    for (int i = 0; i < 200 && !fail; i++) begin
      cycle();
      if (!fail) begin
        if (pll_reset) hi++; else lo++;
        if (pll_reset && !prev) rises++;
        prev = pll_reset;
      end
    end
    check_eq("s2_fail", 32'(fail), 32'd1);
    check_eq("s2_pulses", 32'(rises), 32'd2);
    check_eq("s2_high_cycles", 32'(hi), 32'(2 * RST_CYC));
    check_eq("s2_low_cycles", 32'(lo), 32'(2 * LOCK_TIMEOUT_CYC));
    repeat (10) cycle();
    check_eq("s2_fail_held", {30'd0, pll_reset, fail}, 32'b11);
    pulse_restart();
    check_eq("s2_restart", {30'd0, pll_reset, fail}, 32'b10);
    repeat (4) cycle();
    check_eq("s2_new_pulse_end", 32'(pll_reset), 32'd0);

    // Scenario 6: reset mid-STABLE
    pll_lock = 1'b1;
    repeat (6) cycle();
    reset_n = 1'b0;
    cycle();
    check_eq("s6_reset_outs", {20'd0, pll_reset, sys_rst_n, pll_ready, fail, relock_cnt},
             {20'd0, 4'b1000, 8'd0});
    reset_n = 1'b1;

    // Random phase
    seg = 0;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        pll_lock = ($urandom_range(0, 2) != 0);
        seg = pll_lock ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
      end
      seg--;
      restart_req = ($urandom_range(0, 99) == 0);
      reset_n     = ($urandom_range(0, 399) != 0);
      cycle();
    end
    restart_req = 1'b0;
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
